// File: rtl/sram2rw_arbiter_pkg.sv
// rtl/sram2rw_arbiter_pkg.sv - shared constants, types and index helper for the 2RW SRAM arbiter
package sram_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  // Clear counter walks address pairs, so it needs one bit less than the address.
  localparam int CLR_W  = ADDR_W - 1;
  // Requester index width; covers up to 8 requesters.
  localparam int IDX_W  = 3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Registered with every read grant so the macro output is routed back next cycle.
  typedef struct packed {
    logic             valid;
    logic             port;   // 0 = macro port 1, 1 = macro port 2
    logic [IDX_W-1:0] idx;
  } port_tag_t;

  // Fold an index that is at most 2*n-1 back into 0..n-1.
  function automatic logic [IDX_W-1:0] idx_wrap(input logic [IDX_W:0] v,
                                                input logic [IDX_W:0] n);
    return (v >= n) ? IDX_W'(v - n) : IDX_W'(v);
  endfunction

endpackage

// File: rtl/sram2rw_arbiter_if.sv
// rtl/sram2rw_arbiter_if.sv - requester handshake and 2RW macro pin bundle
interface sram2rw_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0]         sram_a1;
  logic [ADDR_W-1:0]         sram_a2;
  logic [DATA_W-1:0]         sram_i1;
  logic [DATA_W-1:0]         sram_i2;
  logic [DATA_W-1:0]         sram_o1;
  logic [DATA_W-1:0]         sram_o2;
  logic                      sram_csb1;
  logic                      sram_csb2;
  logic                      sram_oeb1;
  logic                      sram_oeb2;
  logic                      sram_web1;
  logic                      sram_web2;

  // Arbiter side: sees requests and macro outputs, drives grants, responses and macro pins.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, sram_o1, sram_o2,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_a1, sram_a2, sram_i1, sram_i2,
    output sram_csb1, sram_csb2, sram_oeb1, sram_oeb2, sram_web1, sram_web2
  );

  // Requester/macro side: the mirror image.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, sram_o1, sram_o2,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_a1, sram_a2, sram_i1, sram_i2,
    input  sram_csb1, sram_csb2, sram_oeb1, sram_oeb2, sram_web1, sram_web2
  );

endinterface

// File: rtl/sram2rw_arbiter_rr_pick2.sv
// rtl/sram2rw_arbiter_rr_pick2.sv - combinational round-robin picker returning the first two valid requesters
module rr_pick2
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] g1_o,
  output logic [NUM_REQ-1:0] g2_o,
  output logic [IDX_W-1:0]   g1_idx_o,
  output logic [IDX_W-1:0]   g2_idx_o,
  output logic               found1_o,
  output logic               found2_o
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  // Scan from ptr_i upward with wrap; the first valid goes to port 1, the next to port 2.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx      = '0;
    found1_o = 1'b0;
    found2_o = 1'b0;
    g1_idx_o = '0;
    g2_idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = idx_wrap({1'b0, ptr_i} + (IDX_W+1)'(k), NREQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (idx == IDX_W'(i) && valid_i[i]) begin
          if (!found1_o) begin
            found1_o = 1'b1;
            g1_idx_o = idx;
          end else if (!found2_o) begin
            found2_o = 1'b1;
            g2_idx_o = idx;
          end
        end
      end
    end
  end

  // Expand the winning indices to one-hot vectors.
  always_comb begin
    g1_o = '0;
    g2_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      g1_o[i] = found1_o && (g1_idx_o == IDX_W'(i));
      g2_o[i] = found2_o && (g2_idx_o == IDX_W'(i));
    end
  end

endmodule

// File: rtl/sram2rw_arbiter.sv
// rtl/sram2rw_arbiter.sv - 2RW 16x32 SRAM arbiter with power-up clear; SRAM_ARB_STATS_EN adds grant/conflict counters
module sram2rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic             clock,
  input  logic             reset,
  sram2rw_arbiter_if.slave bus,
  output logic             init_done
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]      stat_grants,
  output logic [31:0]      stat_conflicts
`endif
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  state_e            state_q, state_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  port_tag_t         tag1_q, tag1_d;
  port_tag_t         tag2_q, tag2_d;
  logic [ADDR_W-1:0] a1_q, a2_q;
  logic [DATA_W-1:0] i1_q, i2_q;

  logic [NUM_REQ-1:0] g1_oh, g2_oh;
  logic [IDX_W-1:0]   g1_idx, g2_idx;
  logic               found1, found2;

  logic [ADDR_W-1:0]  addr1, addr2;
  logic [DATA_W-1:0]  wdata1, wdata2;
  logic               write1, write2;
  logic               run_active;
  logic               conflict;
  logic               grant1, grant2;

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i  (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .g1_o     (g1_oh),
    .g2_o     (g2_oh),
    .g1_idx_o (g1_idx),
    .g2_idx_o (g2_idx),
    .found1_o (found1),
    .found2_o (found2)
  );

  // Route the two candidates' request fields to their macro ports.
  always_comb begin
    addr1  = '0;
    addr2  = '0;
    wdata1 = '0;
    wdata2 = '0;
    write1 = 1'b0;
    write2 = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g1_oh[i]) begin
        addr1  = bus.req_addr[i*ADDR_W +: ADDR_W];
        wdata1 = bus.req_wdata[i*DATA_W +: DATA_W];
        write1 = bus.req_write[i];
      end
      if (g2_oh[i]) begin
        addr2  = bus.req_addr[i*ADDR_W +: ADDR_W];
        wdata2 = bus.req_wdata[i*DATA_W +: DATA_W];
        write2 = bus.req_write[i];
      end
    end
  end

  // Same address with any write on either port would race inside the macro, so port 2 backs off.
  assign run_active = (state_q == RUN) && !reset;
  assign conflict   = found1 && found2 && (addr1 == addr2) && (write1 || write2);
  assign grant1     = run_active && found1;
  assign grant2     = run_active && found2 && !conflict;
  assign init_done  = (state_q == RUN);

  // Next-state, macro pins, grants, response tags and pointer update.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    tag1_d        = '0;
    tag2_d        = '0;
    bus.req_ready = '0;
    bus.sram_csb1 = 1'b1;
    bus.sram_oeb1 = 1'b1;
    bus.sram_web1 = 1'b1;
    bus.sram_csb2 = 1'b1;
    bus.sram_oeb2 = 1'b1;
    bus.sram_web2 = 1'b1;
    bus.sram_a1   = a1_q;
    bus.sram_i1   = i1_q;
    bus.sram_a2   = a2_q;
    bus.sram_i2   = i2_q;
    if (!reset) begin
      unique case (state_q)
        CLEAR: begin
          bus.sram_csb1 = 1'b0;
          bus.sram_web1 = 1'b0;
          bus.sram_a1   = {clr_cnt_q, 1'b0};
          bus.sram_i1   = '0;
          bus.sram_csb2 = 1'b0;
          bus.sram_web2 = 1'b0;
          bus.sram_a2   = {clr_cnt_q, 1'b1};
          bus.sram_i2   = '0;
          clr_cnt_d     = clr_cnt_q + CLR_W'(1);
          if (clr_cnt_q == CLR_W'(DEPTH/2 - 1)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (grant1) begin
            bus.req_ready = bus.req_ready | g1_oh;
            bus.sram_csb1 = 1'b0;
            bus.sram_oeb1 = write1;
            bus.sram_web1 = !write1;
            bus.sram_a1   = addr1;
            bus.sram_i1   = wdata1;
            tag1_d.valid  = !write1;
            tag1_d.port   = 1'b0;
            tag1_d.idx    = g1_idx;
            rr_ptr_d      = idx_wrap({1'b0, g1_idx} + (IDX_W+1)'(1), NREQ);
          end
          if (grant2) begin
            bus.req_ready = bus.req_ready | g2_oh;
            bus.sram_csb2 = 1'b0;
            bus.sram_oeb2 = write2;
            bus.sram_web2 = !write2;
            bus.sram_a2   = addr2;
            bus.sram_i2   = wdata2;
            tag2_d.valid  = !write2;
            tag2_d.port   = 1'b1;
            tag2_d.idx    = g2_idx;
            rr_ptr_d      = idx_wrap({1'b0, g2_idx} + (IDX_W+1)'(1), NREQ);
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  // State, counters, tags and held address/data registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rr_ptr_q  <= '0;
      tag1_q    <= '0;
      tag2_q    <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag2_d;
      a1_q      <= bus.sram_a1;
      a2_q      <= bus.sram_a2;
      i1_q      <= bus.sram_i1;
      i2_q      <= bus.sram_i2;
    end
  end

  // Steer macro read data back to the requester recorded in last cycle's tags.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!reset && tag1_q.valid && tag1_q.idx == IDX_W'(i)) begin
        bus.rsp_valid[i]                 = 1'b1;
        bus.rsp_rdata[i*DATA_W +: DATA_W] = tag1_q.port ? bus.sram_o2 : bus.sram_o1;
      end
      if (!reset && tag2_q.valid && tag2_q.idx == IDX_W'(i)) begin
        bus.rsp_valid[i]                 = 1'b1;
        bus.rsp_rdata[i*DATA_W +: DATA_W] = tag2_q.port ? bus.sram_o2 : bus.sram_o1;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_grants_d;
  logic [31:0] stat_conflicts_q, stat_conflicts_d;
  logic [1:0]  n_grants;
  logic [32:0] grants_sum;

  // Saturating counters of handshakes and conflict-withheld cycles.
  always_comb begin
    n_grants         = {1'b0, grant1} + {1'b0, grant2};
    grants_sum       = {1'b0, stat_grants_q} + 33'(n_grants);
    stat_grants_d    = grants_sum[32] ? '1 : grants_sum[31:0];
    stat_conflicts_d = stat_conflicts_q;
    if (run_active && conflict && (stat_conflicts_q != '1)) begin
      stat_conflicts_d = stat_conflicts_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_grants_q    <= '0;
      stat_conflicts_q <= '0;
    end else begin
      stat_grants_q    <= stat_grants_d;
      stat_conflicts_q <= stat_conflicts_d;
    end
  end

  assign stat_grants    = stat_grants_q;
  assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_sram2rw_arbiter.sv
// tb/tb_sram2rw_arbiter.sv - randomized and directed bench for sram2rw_arbiter against a reference model
module tb_sram2rw_arbiter;
  import sram_arb_pkg::*;

  localparam int NR = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic init_done;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_grants;
  logic [31:0] stat_conflicts;
`endif

  sram2rw_arbiter_if #(.NUM_REQ(NR)) bus ();

  sram2rw_arbiter #(.NUM_REQ(NR)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural 2RW macro, starting with non-zero contents.
  logic [DATA_W-1:0] macro_mem [DEPTH] = '{default: 32'hBAD0_F00D};
  always @(posedge clock) begin
    if (!bus.sram_csb1 && !bus.sram_web1) macro_mem[bus.sram_a1] <= bus.sram_i1;
    if (!bus.sram_csb2 && !bus.sram_web2) macro_mem[bus.sram_a2] <= bus.sram_i2;
    if (!bus.sram_csb1 && !bus.sram_oeb1) bus.sram_o1 <= macro_mem[bus.sram_a1];
    if (!bus.sram_csb2 && !bus.sram_oeb2) bus.sram_o2 <= macro_mem[bus.sram_a2];
  end

  int tests  = 0;
  int errors = 0;

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ptr;
  int                clear_left;
  logic [NR-1:0]     exp_rsp_v;
  logic [DATA_W-1:0] exp_rsp_d [NR];
  int                exp_grants;
  int                exp_conf;
  int                grant_cnt [NR];

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] r_addr(input int i);
    return bus.req_addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] r_data(input int i);
    return bus.req_wdata[i*DATA_W +: DATA_W];
  endfunction

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid[i]                  = v;
    bus.req_write[i]                  = w;
    bus.req_addr[i*ADDR_W +: ADDR_W]  = a;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  // Check one port's pins against the requester it should be serving (-1 = idle).
  task automatic check_port(input string p, input int g, input logic csb, input logic web,
                            input logic oeb, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (g >= 0) begin
      expect_eq({p, "_ctl"}, {csb, web, oeb}, {1'b0, !bus.req_write[g], bus.req_write[g]});
      expect_eq({p, "_addr"}, a, r_addr(g));
      if (bus.req_write[g]) expect_eq({p, "_wdata"}, d, r_data(g));
    end else begin
      expect_eq({p, "_idle"}, {csb, web, oeb}, 3'b111);
    end
  endtask

  // One clock of checking plus model update; entered and left at posedge+1.
  task automatic run_cycle();
    int order[$];
    int g1, g2, last;
    logic [NR-1:0] exp_ready;
    #4;
    expect_eq("rsp_valid", bus.rsp_valid, exp_rsp_v);
    for (int i = 0; i < NR; i++)
      if (exp_rsp_v[i]) expect_eq($sformatf("rsp_rdata%0d", i), bus.rsp_rdata[i*DATA_W +: DATA_W], exp_rsp_d[i]);
`ifdef SRAM_ARB_STATS_EN
    expect_eq("stat_grants", stat_grants, exp_grants);
    expect_eq("stat_conflicts", stat_conflicts, exp_conf);
`endif
    exp_rsp_v = '0;
    if (clear_left > 0) begin
      int k;
      k = DEPTH/2 - clear_left;
      expect_eq("clr_init_done", init_done, 0);
      expect_eq("clr_ready", bus.req_ready, 0);
      expect_eq("clr_ctl", {bus.sram_csb1, bus.sram_web1, bus.sram_csb2, bus.sram_web2}, 4'b0000);
      expect_eq("clr_a1", bus.sram_a1, 2*k);
      expect_eq("clr_a2", bus.sram_a2, 2*k + 1);
      expect_eq("clr_data", {bus.sram_i1, bus.sram_i2}, 0);
      clear_left--;
    end else begin
      expect_eq("init_done", init_done, 1);
      for (int k = 0; k < NR; k++) begin
        int r;
        r = (ptr + k) % NR;
        if (bus.req_valid[r]) order.push_back(r);
      end
      g1 = (order.size() > 0) ? order[0] : -1;
      g2 = (order.size() > 1) ? order[1] : -1;
      if (g2 >= 0 && r_addr(g1) == r_addr(g2) && (bus.req_write[g1] || bus.req_write[g2])) begin
        g2 = -1;
        exp_conf++;
      end
      exp_ready = '0;
      if (g1 >= 0) exp_ready[g1] = 1'b1;
      if (g2 >= 0) exp_ready[g2] = 1'b1;
      expect_eq("ready", bus.req_ready, exp_ready);
      check_port("p1", g1, bus.sram_csb1, bus.sram_web1, bus.sram_oeb1, bus.sram_a1, bus.sram_i1);
      check_port("p2", g2, bus.sram_csb2, bus.sram_web2, bus.sram_oeb2, bus.sram_a2, bus.sram_i2);
      // Reads see the array before this edge; a granted pair never mixes a write with the same address.
      foreach (order[j]) begin
        int g;
        g = order[j];
        if (g == g1 || g == g2) begin
          exp_grants++;
          grant_cnt[g]++;
          if (!bus.req_write[g]) begin
            exp_rsp_v[g] = 1'b1;
            exp_rsp_d[g] = ref_mem[r_addr(g)];
          end
        end
      end
      if (g1 >= 0 && bus.req_write[g1]) ref_mem[r_addr(g1)] = r_data(g1);
      if (g2 >= 0 && bus.req_write[g2]) ref_mem[r_addr(g2)] = r_data(g2);
      last = (g2 >= 0) ? g2 : g1;
      if (last >= 0) ptr = (last + 1) % NR;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    clear_reqs();
    repeat (n) begin
      @(posedge clock);
      #1;
      expect_eq("rst_ready", bus.req_ready, 0);
      expect_eq("rst_rsp", bus.rsp_valid, 0);
      expect_eq("rst_pins", {bus.sram_csb1, bus.sram_csb2, bus.sram_oeb1, bus.sram_oeb2,
                             bus.sram_web1, bus.sram_web2}, 6'h3f);
      expect_eq("rst_init_done", init_done, 0);
    end
    reset      = 1'b0;
    ptr        = 0;
    clear_left = DEPTH/2;
    exp_rsp_v  = '0;
    exp_grants = 0;
    exp_conf   = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic read_sweep();
    for (int a = 0; a < DEPTH; a += 2) begin
      clear_reqs();
      set_req(0, 1'b1, 1'b0, ADDR_W'(a), '0);
      set_req(1, 1'b1, 1'b0, ADDR_W'(a + 1), '0);
      run_cycle();
    end
    clear_reqs();
    run_cycle();
  endtask

  initial begin
    clear_reqs();
    #1;
    apply_reset(2);
    repeat (DEPTH/2) run_cycle();
    read_sweep();

    // All four read distinct addresses continuously.
    for (int i = 0; i < NR; i++) begin
      set_req(i, 1'b1, 1'b0, ADDR_W'(8 + i), '0);
      grant_cnt[i] = 0;
    end
    repeat (6) run_cycle();
    clear_reqs();
    run_cycle();
    for (int i = 0; i < NR; i++) expect_eq($sformatf("fair_cnt%0d", i), grant_cnt[i], 3);

    // Write then read back on requester 0.
    set_req(0, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
    run_cycle();
    set_req(0, 1'b1, 1'b0, 4'd3, '0);
    run_cycle();
    clear_reqs();
    expect_eq("beef_valid", bus.rsp_valid, 4'b0001);
    expect_eq("beef_data", bus.rsp_rdata[0 +: DATA_W], 32'hDEAD_BEEF);
    run_cycle();

    // Write/read conflict on address 5 with the pointer at 1.
    expect_eq("ptr_before_conflict", ptr, 1);
    set_req(1, 1'b1, 1'b1, 4'd5, 32'h1234_5678);
    set_req(2, 1'b1, 1'b0, 4'd5, '0);
    run_cycle();
    set_req(1, 1'b0, 1'b0, '0, '0);
    run_cycle();
    clear_reqs();
    expect_eq("conf_rsp_valid", bus.rsp_valid, 4'b0100);
    expect_eq("conf_rsp_data", bus.rsp_rdata[2*DATA_W +: DATA_W], 32'h1234_5678);
    run_cycle();

    // Two reads of the same address are both served.
    set_req(0, 1'b1, 1'b0, 4'd7, '0);
    set_req(3, 1'b1, 1'b0, 4'd7, '0);
    run_cycle();
    clear_reqs();
    expect_eq("same_rd_valid", bus.rsp_valid, 4'b1001);
    expect_eq("same_rd_d0", bus.rsp_rdata[0 +: DATA_W], 32'h0);
    expect_eq("same_rd_d3", bus.rsp_rdata[3*DATA_W +: DATA_W], 32'h0);
    run_cycle();

    // Randomized traffic, biased toward a few addresses to provoke conflicts.
    repeat (400) begin
      for (int i = 0; i < NR; i++) begin
        logic [ADDR_W-1:0] a;
        a = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom_range(0, 15));
        set_req(i, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a, $urandom);
      end
      run_cycle();
    end

    // Reset lands mid-clear and the clear restarts from the bottom.
    apply_reset(1);
    repeat (4) run_cycle();
    apply_reset(1);
    repeat (DEPTH/2) run_cycle();
    read_sweep();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
